// File: rtl/ddr_pkg.sv
// Shared MCB constants, frame-buffer layout and reader state encoding.
// Used by both the port-0 pixel writer and the port-1 frame reader.
package ddr_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int unsigned DEF_BURST_LEN = 32;
    localparam int unsigned FRAME_WORDS   = 307200;
    localparam logic [29:0] FRAME0_BASE   = 30'd0;
    localparam logic [29:0] FRAME1_BASE   = 30'd5242880;

    typedef enum logic [3:0] {
        ST_WAIT_CALIB = 4'd0,
        ST_IDLE       = 4'd1,
        ST_CMD        = 4'd2,
        ST_DRAIN      = 4'd3
    } state_e;

    // Byte address of a 32-bit word offset within a frame buffer.
    function automatic logic [29:0] word_addr(input logic [29:0] base, input logic [19:0] ptr);
        return base + {8'd0, ptr, 2'b00};
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single level signal crossing into clk.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so both flops sample on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ddr_port1_reader.sv
// Double-buffered frame reader: issues fixed-length MCB port-1 read bursts and
// streams the returned words to the display pixel FIFO.
module ddr_port1_reader #(
    parameter int unsigned BURST_LEN   = ddr_pkg::DEF_BURST_LEN,
    parameter int unsigned FRAME_WORDS = ddr_pkg::FRAME_WORDS,
    parameter logic [29:0] FRAME0_BASE = ddr_pkg::FRAME0_BASE,
    parameter logic [29:0] FRAME1_BASE = ddr_pkg::FRAME1_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_calib_done,
    input  logic        frame_select,
    input  logic        frame_restart,
    input  logic [9:0]  out_space,
    input  logic        p1_cmd_full,
    input  logic        p1_rd_empty,
    input  logic [31:0] p1_rd_data,
    output logic        p1_cmd_en,
    output logic [2:0]  p1_cmd_instr,
    output logic [5:0]  p1_cmd_bl,
    output logic [29:0] p1_cmd_byte_addr,
    output logic        p1_rd_en,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    output logic        frame_done,
    output logic [3:0]  LED
);

    import ddr_pkg::*;

    localparam logic [9:0]  BURST_SPACE = 10'(BURST_LEN);
    localparam logic [6:0]  LAST_WORD   = 7'(BURST_LEN - 1);
    localparam logic [5:0]  CMD_BL      = 6'(BURST_LEN - 1);
    localparam logic [19:0] PTR_STEP    = 20'(BURST_LEN);
    localparam logic [19:0] PTR_LIMIT   = 20'(FRAME_WORDS);

    logic        calib_sync;
    state_e      state_q,        state_d;
    logic [19:0] ptr_q,          ptr_d;
    logic        active_buf_q,   active_buf_d;
    logic        restart_pend_q, restart_pend_d;
    logic [6:0]  word_cnt_q,     word_cnt_d;
    logic [31:0] pix_data_q,     pix_data_d;
    logic        pix_valid_q,    pix_valid_d;
    logic        frame_done_q,   frame_done_d;
    logic [3:0]  led_q;
    logic [19:0] ptr_next;
    logic        abort;

    sync2 u_calib_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (mem_calib_done),
        .q_o   (calib_sync)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_WAIT_CALIB;
            ptr_q          <= '0;
            active_buf_q   <= 1'b0;
            restart_pend_q <= 1'b0;
            word_cnt_q     <= '0;
            pix_data_q     <= '0;
            pix_valid_q    <= 1'b0;
            frame_done_q   <= 1'b0;
            led_q          <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            active_buf_q   <= active_buf_d;
            restart_pend_q <= restart_pend_d;
            word_cnt_q     <= word_cnt_d;
            pix_data_q     <= pix_data_d;
            pix_valid_q    <= pix_valid_d;
            frame_done_q   <= frame_done_d;
            led_q          <= state_q;
        end
    end

    // A restart seen now or earlier in the burst voids the rest of it.
    assign abort    = restart_pend_q | frame_restart;
    assign ptr_next = ptr_q + PTR_STEP;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        active_buf_d     = active_buf_q;
        restart_pend_d   = restart_pend_q;
        word_cnt_d       = word_cnt_q;
        pix_data_d       = pix_data_q;
        pix_valid_d      = 1'b0;
        frame_done_d     = 1'b0;
        p1_cmd_en        = 1'b0;
        p1_cmd_bl        = '0;
        p1_cmd_byte_addr = '0;
        p1_rd_en         = 1'b0;

        case (state_q)
            ST_WAIT_CALIB: begin
                if (calib_sync) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (frame_restart || restart_pend_q) begin
                    ptr_d          = '0;
                    active_buf_d   = frame_select;
                    restart_pend_d = 1'b0;
                end else if (!p1_cmd_full && out_space >= BURST_SPACE) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                p1_cmd_en        = 1'b1;
                p1_cmd_bl        = CMD_BL;
                p1_cmd_byte_addr = word_addr(active_buf_q ? FRAME1_BASE : FRAME0_BASE, ptr_q);
                word_cnt_d       = '0;
                state_d          = ST_DRAIN;
                if (frame_restart) restart_pend_d = 1'b1;
            end
            ST_DRAIN: begin
                if (frame_restart) restart_pend_d = 1'b1;
                if (!p1_rd_empty) begin
                    p1_rd_en    = 1'b1;
                    pix_data_d  = p1_rd_data;
                    pix_valid_d = !abort;
                    word_cnt_d  = word_cnt_q + 7'd1;
                    if (word_cnt_q == LAST_WORD) begin
                        state_d = ST_IDLE;
                        // An aborted burst leaves the pointer for the IDLE restart to clear.
                        if (!abort) begin
                            if (ptr_next >= PTR_LIMIT) begin
                                ptr_d        = '0;
                                active_buf_d = frame_select;
                                frame_done_d = 1'b1;
                            end else begin
                                ptr_d = ptr_next;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_WAIT_CALIB;
        endcase
    end

    assign p1_cmd_instr = CMD_READ;
    assign pix_data     = pix_data_q;
    assign pix_valid    = pix_valid_q;
    assign frame_done   = frame_done_q;
    assign LED          = led_q;

endmodule

// File: tb/tb_ddr_port1_reader.sv
// Randomised bench for ddr_port1_reader: MCB port-1 model plus a frame-level
// reference of burst addresses, pixel stream and frame_done pulses.
module tb_ddr_port1_reader;

    localparam int          BURST  = 32;
    localparam int          FWORDS = 64;
    localparam logic [29:0] BASE0  = 30'd0;
    localparam logic [29:0] BASE1  = 30'd5242880;

    logic        clk;
    logic        reset;
    logic        mem_calib_done;
    logic        frame_select;
    logic        frame_restart;
    logic [9:0]  out_space;
    logic        p1_cmd_full;
    logic        p1_rd_empty;
    logic [31:0] p1_rd_data;
    logic        p1_cmd_en;
    logic [2:0]  p1_cmd_instr;
    logic [5:0]  p1_cmd_bl;
    logic [29:0] p1_cmd_byte_addr;
    logic        p1_rd_en;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        frame_done;
    logic [3:0]  LED;

    ddr_port1_reader #(
        .BURST_LEN   (BURST),
        .FRAME_WORDS (FWORDS),
        .FRAME0_BASE (BASE0),
        .FRAME1_BASE (BASE1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_calib_done   (mem_calib_done),
        .frame_select     (frame_select),
        .frame_restart    (frame_restart),
        .out_space        (out_space),
        .p1_cmd_full      (p1_cmd_full),
        .p1_rd_empty      (p1_rd_empty),
        .p1_rd_data       (p1_rd_data),
        .p1_cmd_en        (p1_cmd_en),
        .p1_cmd_instr     (p1_cmd_instr),
        .p1_cmd_bl        (p1_cmd_bl),
        .p1_cmd_byte_addr (p1_cmd_byte_addr),
        .p1_rd_en         (p1_rd_en),
        .pix_data         (pix_data),
        .pix_valid        (pix_valid),
        .frame_done       (frame_done),
        .LED              (LED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests;
    int          n_fail;
    logic [31:0] mcb_q[$];
    int          outstanding;
    int          word_ctr;
    int          model_ptr;
    logic        model_buf;
    logic        aborted;
    int          restart_at;
    logic        restart_last;
    logic        exp_valid;
    logic        exp_valid_dc;
    logic        exp_done;
    logic [31:0] exp_data;
    logic        cmd_now;
    logic [29:0] last_addr;
    logic        last_full;
    logic [9:0]  last_space;
    logic        rand_full;
    int          n_pix;
    int          n_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs on the falling edge, sample outputs 1ns later,
    // then advance the reference by whatever the next rising edge will do.
    task automatic step();
        logic        restart;
        logic [29:0] exp_addr;
        @(negedge clk);
        last_full   = p1_cmd_full;
        last_space  = out_space;
        restart     = 1'b0;
        p1_cmd_full = rand_full && ($urandom_range(0, 3) == 0);
        p1_rd_empty = (mcb_q.size() == 0) || ($urandom_range(0, 3) == 0);
        if (outstanding > 0 && restart_at >= 0 && (BURST - outstanding) == restart_at) begin
            restart     = 1'b1;
            p1_rd_empty = 1'b1;
            restart_at  = -1;
        end
        if (outstanding == 1 && restart_last && !p1_rd_empty) begin
            restart      = 1'b1;
            restart_last = 1'b0;
        end
        frame_restart = restart;
        p1_rd_data    = (mcb_q.size() != 0) ? mcb_q[0] : $urandom;
        #1;

        if (!exp_valid_dc) check("pix_valid", 32'(pix_valid), 32'(exp_valid));
        if (exp_valid && !exp_valid_dc) check("pix_data", pix_data, exp_data);
        check("frame_done", 32'(frame_done), 32'(exp_done));
        check("p1_rd_en", 32'(p1_rd_en), 32'(!p1_rd_empty));
        if (pix_valid) n_pix++;
        if (frame_done) n_done++;

        cmd_now = p1_cmd_en;
        if (p1_cmd_en) begin
            exp_addr  = (model_buf ? BASE1 : BASE0) + 30'(model_ptr * 4);
            last_addr = p1_cmd_byte_addr;
            check("cmd_while_busy", outstanding, 0);
            check("cmd_gate", 32'({last_full, last_space >= 10'd32}), 32'd1);
            check("cmd_addr", 32'(p1_cmd_byte_addr), 32'(exp_addr));
            check("cmd_bl", 32'(p1_cmd_bl), 32'd31);
            check("cmd_instr", 32'(p1_cmd_instr), 32'd1);
            for (int i = 0; i < BURST; i++) begin
                mcb_q.push_back(word_ctr);
                word_ctr++;
            end
            outstanding = BURST;
            aborted     = 1'b0;
        end

        exp_valid    = 1'b0;
        exp_valid_dc = 1'b0;
        exp_done     = 1'b0;
        if (!p1_rd_empty) begin
            exp_data     = mcb_q.pop_front();
            exp_valid    = !aborted && !restart;
            exp_valid_dc = restart;
            outstanding--;
            if (outstanding == 0) begin
                if (aborted || restart) begin
                    model_ptr = 0;
                    model_buf = frame_select;
                end else begin
                    model_ptr += BURST;
                    if (model_ptr >= FWORDS) begin
                        model_ptr = 0;
                        model_buf = frame_select;
                        exp_done  = 1'b1;
                    end
                end
            end
        end
        if (restart) aborted = 1'b1;
    endtask

    task automatic wait_cmd();
        int budget;
        budget = 0;
        do begin
            step();
            budget++;
        end while (!cmd_now && budget < 1000);
        if (!cmd_now) check("cmd_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_idle();
        int budget;
        budget = 0;
        while (outstanding > 0 && budget < 1000) begin
            step();
            budget++;
        end
        check("drain_timeout", outstanding, 0);
    endtask

    task automatic model_clear();
        mcb_q.delete();
        outstanding  = 0;
        model_ptr    = 0;
        model_buf    = 1'b0;
        aborted      = 1'b0;
        restart_at   = -1;
        restart_last = 1'b0;
        exp_valid    = 1'b0;
        exp_valid_dc = 1'b0;
        exp_done     = 1'b0;
    endtask

    initial begin
        int cyc;
        int n0;
        int d0;
        n_tests = 0;
        n_fail  = 0;
        word_ctr = 0;
        n_pix   = 0;
        n_done  = 0;
        cmd_now = 1'b0;
        last_addr = '0;
        exp_data  = '0;
        rand_full = 1'b0;
        model_clear();

        reset          = 1'b1;
        mem_calib_done = 1'b0;
        frame_select   = 1'b0;
        frame_restart  = 1'b0;
        out_space      = 10'd512;
        p1_cmd_full    = 1'b0;
        p1_rd_empty    = 1'b1;
        p1_rd_data     = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cmd_en", 32'(p1_cmd_en), 32'd0);
        check("rst_instr", 32'(p1_cmd_instr), 32'd1);
        check("rst_bl", 32'(p1_cmd_bl), 32'd0);
        check("rst_addr", 32'(p1_cmd_byte_addr), 32'd0);
        check("rst_rd_en", 32'(p1_rd_en), 32'd0);
        check("rst_pix_data", pix_data, 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_led", 32'(LED), 32'd0);
        reset = 1'b0;

        // Calibration held low: nothing may be issued.
        for (int i = 0; i < 100; i++) begin
            step();
            check("pre_calib_cmd", 32'(p1_cmd_en), 32'd0);
        end
        mem_calib_done = 1'b1;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!cmd_now && cyc < 20);
        check("calib_latency", cyc, 4);
        check("first_addr", 32'(last_addr), 32'd0);

        // First burst: 32 words 0..31 in order.
        run_idle();
        step();
        check("first_burst_pix", n_pix, 32);
        wait_cmd();
        check("second_addr", 32'(last_addr), 32'd128);

        // Downstream space one short of a burst blocks the next command.
        out_space = 10'd31;
        run_idle();
        for (int i = 0; i < 20; i++) begin
            step();
            check("space_hold", 32'(p1_cmd_en), 32'd0);
        end
        check("frame_done_count", n_done, 1);
        out_space = 10'd32;
        step();
        check("space_release", 32'(p1_cmd_en), 32'd1);
        check("wrap_addr", 32'(last_addr), 32'd0);
        out_space = 10'd512;

        // frame_select flips mid-frame: buffer 0 is kept until the wrap.
        frame_select = 1'b1;
        wait_cmd();
        check("fs_hold_addr", 32'(last_addr), 32'd128);
        wait_cmd();
        check("fs_wrap_addr", 32'(last_addr), 32'd5242880);
        wait_cmd();
        check("fs_second_addr", 32'(last_addr), 32'd5243008);
        wait_cmd();
        check("fs_rewrap_addr", 32'(last_addr), 32'd5242880);

        // Restart after 10 words of a burst at word 0.
        restart_at = 10;
        n0 = n_pix;
        d0 = n_done;
        wait_cmd();
        check("restart_addr", 32'(last_addr), 32'd5242880);
        check("restart_pix", n_pix - n0, 10);
        check("restart_no_done", n_done, d0);

        // Restart coincident with the final pop of the frame.
        wait_cmd();
        check("last_burst_addr", 32'(last_addr), 32'd5243008);
        restart_last = 1'b1;
        d0 = n_done;
        wait_cmd();
        check("last_restart_addr", 32'(last_addr), 32'd5242880);
        check("last_restart_no_done", n_done, d0);

        // Random command-FIFO back-pressure and downstream space.
        rand_full = 1'b1;
        for (int i = 0; i < 6; i++) begin
            out_space = 10'($urandom_range(32, 1023));
            wait_cmd();
        end
        rand_full   = 1'b0;
        p1_cmd_full = 1'b0;

        // Reset in the middle of a burst.
        repeat (5) step();
        reset = 1'b1;
        #1;
        check("midrst_pix_valid", 32'(pix_valid), 32'd0);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        check("midrst_cmd_en", 32'(p1_cmd_en), 32'd0);
        check("midrst_rd_en", 32'(p1_rd_en), 32'd0);
        check("midrst_led", 32'(LED), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        wait_cmd();
        check("post_reset_addr", 32'(last_addr), 32'd0);
        run_idle();
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_port1_reader.md
Name: ddr_port1_reader

Overview:
- Read-side counterpart to the port-0 pixel writer.
- Fetches finished frame data from DDR through MCB user port 1 in fixed-length read bursts.
- Streams the words to the display-side pixel FIFO.
- Double-buffered: reads the frame buffer selected by frame_select while the renderer writes the other one.

Parameters:
- burst_len, 32, words per read command (1..64); p1_cmd_bl = burst_len-1
- frame_words, 307200, 32-bit words per frame (640x480)
- frame0_base, 0, byte address of buffer 0
- frame1_base, 5242880, byte address of buffer 1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mem_calib_done  in  1  MCB calibration complete (asynchronous to clk)
- frame_select  in  1  buffer to display; sampled only at frame boundaries
- frame_restart  in  1  one-cycle pulse from display vsync: restart at word 0
- out_space  in  10  free entries in the downstream pixel FIFO
- p1_cmd_full  in  1  MCB command FIFO full
- p1_rd_empty  in  1  MCB read FIFO empty
- p1_rd_data  in  32  MCB read FIFO head; valid whenever !p1_rd_empty
- p1_cmd_en  out  1  command strobe
- p1_cmd_instr  out  3  command code; 3'b001 = read
- p1_cmd_bl  out  6  burst length minus one
- p1_cmd_byte_addr  out  30  byte address
- p1_rd_en  out  1  read FIFO pop
- pix_data  out  32  pixel word to the display FIFO
- pix_valid  out  1  pix_data write strobe
- frame_done  out  1  one-cycle pulse after the last word of a frame
- LED  out  4  registered copy of state, for debug

Behaviour:
- Reset values: all outputs 0; p1_cmd_instr=3'b001; pointer=0; active_buf=0; restart_pend=0; state=WAIT_CALIB.
- mem_calib_done passes through a 2-flop synchroniser before use.
- WAIT_CALIB: move to IDLE when the synchronised calib bit is 1.
- IDLE:
  - On frame_restart, or when restart_pend is set: pointer<=0, active_buf<=frame_select, clear restart_pend. No command is issued that cycle.
  - Otherwise, when !p1_cmd_full && out_space>=burst_len: go to CMD.
- CMD (one cycle):
  - p1_cmd_en=1, p1_cmd_bl=burst_len-1.
  - p1_cmd_byte_addr = (active_buf ? frame1_base : frame0_base) + (pointer<<2).
  - Go to DRAIN with word_cnt=0.
- DRAIN:
  - p1_rd_en = !p1_rd_empty (combinational, same cycle).
  - On each pop, register pix_data<=p1_rd_data and pix_valid<=1 (one-cycle latency). Otherwise pix_valid<=0.
  - word_cnt increments per pop.
  - After burst_len pops: pointer += burst_len and return to IDLE.
  - If the new pointer >= frame_words: pointer<=0, active_buf<=frame_select, frame_done pulses one cycle.
- Only one burst is outstanding at a time. The out_space check at issue guarantees the downstream FIFO cannot overflow.
- frame_restart during CMD/DRAIN:
  - Set restart_pend.
  - The burst is still fully popped so the MCB read FIFO stays aligned, but pix_valid is held 0 for the rest of that burst.
  - Pointer reset happens on return to IDLE. The pointer advance and frame_done for the aborted burst are suppressed.
- frame_restart coincident with the last pop: restart wins; frame_done is not pulsed.
- Reset mid-burst returns the block to WAIT_CALIB. The MCB port is reset in the same reset domain.
- frame_select changes mid-frame have no effect until the next wrap or restart.
- Address arithmetic is 30-bit unsigned. The pointer is 20 bits (frame_words < 2^20).
- LED <= state[3:0] every clk.

Decomposition:
- Shared package (ddr_pkg):
  - MCB command codes: CMD_WRITE=3'b000, CMD_READ=3'b001.
  - frame0_base/frame1_base and frame_words constants shared with the port-0 writer.
  - State encoding localparams.
- One natural sub-module: sync2, the 2-flop synchroniser for mem_calib_done. It is reusable by the port-0 writer.

Test Plan:
- Calib low 100 cycles then high, out_space=512, MCB model idle -> no p1_cmd_en before calib+2 cycles; first command has addr 0, bl=31, instr=3'b001.
- Model returns 32 words 0..31 with random empty gaps -> exactly 32 pix_valid pulses, data 0..31 in order, each one cycle after its p1_rd_en; second command addr=128.
- out_space=31 held -> no command issued; raise to 32 -> command on the cycle after IDLE sees it.
- frame_words=64, frame_select=1 -> commands at 5242880 and 5243008; frame_done pulses after word 63; next command back at 5242880.
- frame_select toggled 0->1 mid-frame -> addresses stay in buffer 0 until the wrap, then switch to 5242880.
- frame_restart pulsed at word 10 of a burst -> remaining 22 words popped with pix_valid=0, no frame_done, next command addr = base+0.
